serial_word_rx: RTL and testbench



---
 rtl/serial_word_rx.sv | 103 ++++++++++
 tb/tb_serial_word_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Serial-to-parallel word receiver. Accumulates WIDTH qualified serial
//   bits (MSB-first or LSB-first) into a word and presents it on a one-deep
//   output register with a valid/ready handshake. If a word completes while
//   the output slot is still occupied, the word is dropped and a sticky
//   overrun flag is set.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: first received bit lands in dout[WIDTH-1]; 0: in dout[0]
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   cl          synchronous clear, active-high (same effect as reset)
//   bit_in      serial data bit
//   bit_valid   bit_in is sampled this cycle
//   start       frame start; discards any partial word
//   dout        received word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout
//   busy        partial word in progress (bit_cnt != 0)
//   bit_cnt     bits accumulated in the current word
//   overrun     sticky: a completed word was dropped
module serial_word_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cl,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     start,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             complete;
  logic             slot_free;

  // On start the partial word is discarded, so the new bit shifts into a
  // cleared register rather than the stale contents.
  assign shreg_next = shift_in(start ? '0 : shreg, bit_in);
  assign complete   = bit_valid && !start && (bit_cnt == LAST);
  // The slot is free when empty or when it is being drained on this edge,
  // which lets a completion and a transfer coincide without an overrun.
  assign slot_free  = !dout_valid || dout_ready;
  assign busy       = (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (cl) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Transfer; a simultaneous completion below overrides this.
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      if (start) begin
        bit_cnt <= bit_valid ? CW'(1) : '0;
        shreg   <= bit_valid ? shreg_next : '0;
      end else if (bit_valid) begin
        shreg <= shreg_next;
        if (complete) begin
          bit_cnt <= '0;
          if (slot_free) begin
            dout       <= shreg_next;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Testbench for serial_word_rx: two instances (MSB-first and LSB-first) share
// one stimulus stream. Expected words are queued as stimulus is issued; a
// monitor pops and compares on every handshake transfer.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cl = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       start = 1'b0;
  logic       dout_ready = 1'b0;

  logic [7:0] dout_m, dout_l;
  logic       dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .cl(cl), .bit_in(bit_in), .bit_valid(bit_valid),
    .start(start), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .busy(busy_m), .bit_cnt(cnt_m), .overrun(ovr_m));

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .cl(cl), .bit_in(bit_in), .bit_valid(bit_valid),
    .start(start), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .busy(busy_l), .bit_cnt(cnt_l), .overrun(ovr_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && !cl && dout_ready) begin
      if (dv_m) begin
        if (q_m.size() == 0) check("unexpected_word_m", {24'd0, dout_m}, 32'hxxxx_xxxx);
        else check("word_m", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
      end
      if (dv_l) begin
        if (q_l.size() == 0) check("unexpected_word_l", {24'd0, dout_l}, 32'hxxxx_xxxx);
        else check("word_l", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Sends w MSB of w first; expectations are hand-supplied per instance.
  task automatic send_word(input logic [7:0] w, input logic [7:0] em,
                           input logic [7:0] el, input bit push);
    if (push) begin
      q_m.push_back(em);
      q_l.push_back(el);
    end
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    #1;
    check("rst_dout", {24'd0, dout_m}, 32'h0);
    check("rst_valid", {31'd0, dv_m}, 32'h0);
    check("rst_cnt", {29'd0, cnt_m}, 32'h0);
    check("rst_ovr", {31'd0, ovr_m}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1,1,0,0,0,0,0,0 with ready=1: MSB->C0, LSB->03; bit_cnt 1..7 then 0
    dout_ready = 1'b1;
    q_m.push_back(8'hC0);
    q_l.push_back(8'h03);
    w = 8'hC0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      check("cnt_seq", {29'd0, cnt_m}, (i == 0) ? 32'd0 : 32'(8 - i));
      if (i == 4) check("busy_mid", {31'd0, busy_m}, 32'd1);
    end
    check("valid_after_last", {31'd0, dv_m}, 32'd1);
    check("dout_c0", {24'd0, dout_m}, 32'hC0);
    check("dout_03", {24'd0, dout_l}, 32'h03);
    tick();
    check("valid_one_cycle", {31'd0, dv_m}, 32'd0);
    tick();

    // Same word with 3 idle cycles between bits; bit_cnt holds in gaps
    q_m.push_back(8'hC0);
    q_l.push_back(8'h03);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      repeat (3) tick();
      check("cnt_gap_hold", {29'd0, cnt_l}, (i == 0) ? 32'd0 : 32'(8 - i));
    end
    tick();

    // Stall: 3C kept, FF dropped, overrun set
    dout_ready = 1'b0;
    send_word(8'h3C, 8'h3C, 8'h3C, 1'b1);
    send_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
    tick();
    check("stall_dout", {24'd0, dout_m}, 32'h3C);
    check("stall_valid", {31'd0, dv_m}, 32'd1);
    check("stall_ovr", {31'd0, ovr_m}, 32'd1);
    check("stall_ovr_l", {31'd0, ovr_l}, 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("drain_valid", {31'd0, dv_m}, 32'd0);
    check("ovr_sticky", {31'd0, ovr_m}, 32'd1);
    tick();
    check("ovr_still", {31'd0, ovr_m}, 32'd1);
    cl = 1'b1;
    tick();
    cl = 1'b0;
    check("ovr_cleared", {31'd0, ovr_m}, 32'd0);

    // Back-to-back A5, 5A with ready=1
    dout_ready = 1'b1;
    send_word(8'hA5, 8'hA5, 8'hA5, 1'b1);
    send_word(8'h5A, 8'h5A, 8'h5A, 1'b1);
    tick();
    check("b2b_ovr", {31'd0, ovr_m}, 32'd0);
    tick();

    // Completion coinciding with transfer: valid stays high, new word loads
    dout_ready = 1'b0;
    send_word(8'hA5, 8'hA5, 8'hA5, 1'b1);
    q_m.push_back(8'h5A);
    q_l.push_back(8'h5A);
    w = 8'h5A;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    dout_ready = 1'b1;
    send_bit(w[0]);
    check("coinc_valid", {31'd0, dv_m}, 32'd1);
    check("coinc_dout", {24'd0, dout_m}, 32'h5A);
    check("coinc_ovr", {31'd0, ovr_m}, 32'd0);
    tick();
    check("coinc_drained", {31'd0, dv_m}, 32'd0);

    // Start discards partial: 1,0,1 then start+1 then 7 zeros -> 80 / 01
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    q_m.push_back(8'h80);
    q_l.push_back(8'h01);
    start = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    check("start_cnt", {29'd0, cnt_m}, 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("start_dout", {24'd0, dout_m}, 32'h80);
    tick();

    // Asynchronous reset mid-word with a pending word
    dout_ready = 1'b0;
    send_word(8'h3C, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("pre_rst_cnt", {29'd0, cnt_m}, 32'd5);
    check("pre_rst_valid", {31'd0, dv_m}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_dout", {24'd0, dout_m}, 32'h0);
    check("async_valid", {31'd0, dv_m}, 32'd0);
    check("async_cnt", {29'd0, cnt_m}, 32'd0);
    check("async_busy", {31'd0, busy_m}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    dout_ready = 1'b1;
    send_word(8'hC0, 8'hC0, 8'h03, 1'b1);
    tick();

    // Synchronous clear mid-word: effective only at the edge
    dout_ready = 1'b0;
    send_word(8'h3C, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    cl = 1'b1;
    #2;
    check("cl_before_edge", {31'd0, dv_m}, 32'd1);
    check("cl_before_cnt", {29'd0, cnt_m}, 32'd5);
    @(posedge clk);
    #1;
    cl = 1'b0;
    check("cl_valid", {31'd0, dv_m}, 32'd0);
    check("cl_cnt", {29'd0, cnt_m}, 32'd0);
    check("cl_dout", {24'd0, dout_m}, 32'h0);
    dout_ready = 1'b1;
    send_word(8'hA5, 8'hA5, 8'hA5, 1'b1);
    repeat (3) tick();

    check("queue_m_empty", q_m.size(), 32'd0);
    check("queue_l_empty", q_l.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
